sm83_mem_responder: RTL and testbench
=====================================

// Module: sm83_mem_responder
// PURPOSE
// Memory-side responder for SM83 core bus requests (fetch, operand, indirect, WZ accesses).
// Decodes the 16-bit CPU address and services each request:
// - reads and writes go to ROM (external sync port), internal WRAM, internal HRAM, the OAM
//   write port and the IE and DMA registers;
// - hosts the OAM DMA engine (FF46), which takes over the source bus while it runs.
// PARAMETERS
// WRAM_AW    13   WRAM address width (8 KiB, C000-DFFF, echoed at E000-FDFF)
// HRAM_SIZE  127  HRAM bytes at FF80-FFFE
// DMA_LEN    160  bytes copied per OAM DMA
// PORTS
// clk         in   1   clock
// rst_n       in   1   asynchronous, active-low reset
// cpu_addr    in   16  request address
// cpu_wdata   in   8   write data
// cpu_rd      in   1   read request this cycle
// cpu_wr      in   1   write request this cycle
// cpu_rdata   out  8   read data, valid with cpu_rvalid
// cpu_rvalid  out  1   read data valid (1 cycle after cpu_rd)
// rom_addr    out  15  ROM address (CPU or DMA)
// rom_rd      out  1   ROM read strobe; ROM returns rom_rdata next cycle
// rom_rdata   in   8   ROM read data
// oam_addr    out  8   OAM write address (0-159)
// oam_wdata   out  8   OAM write data
// oam_we      out  1   OAM write enable
// ie          out  8   interrupt-enable register (FFFF)
// dma_active  out  1   DMA in progress
// BEHAVIOUR
// Reset values:
// - cpu_rdata=FF, cpu_rvalid=0, rom_rd=0, rom_addr=0, oam_we=0, oam_addr=0, oam_wdata=0;
// - ie=00, FF46 reg=00, dma_active=0, DMA FSM=IDLE. WRAM/HRAM contents are not reset.
// Request rules:
// - One request per cycle, no stalls.
// - cpu_rd and cpu_wr both high: treated as a write; cpu_rvalid=0 next cycle.
// - Read latency is exactly 1 cycle for every region: data is registered, cpu_rvalid=1 in N+1.
// Address map:
// - 0000-7FFF ROM: read drives rom_addr/rom_rd in N and forwards rom_rdata in N+1.
//   Writes are ignored (no MBC).
// - C000-FDFF WRAM: address is cpu_addr[WRAM_AW-1:0], so E000-FDFF aliases C000-DDFF.
// - FE00-FE9F OAM: write -> oam_we=1 in N+1 with addr=cpu_addr[7:0] and the data.
//   Reads return FF.
// - FF46 DMA: read returns the last value written. Write of X starts DMA from X<<8.
// - FF80-FFFE HRAM read/write; FFFF IE read/write.
// - All other addresses: read FF, write ignored.
// DMA FSM: IDLE -> START -> RD -> WR -> RD ... -> IDLE.
// - START: lasts 1 cycle; dma_active=1 from START onwards.
// - RD: issues source read for byte i (src = {X,8'(i)}).
//   ROM sources (X 00-7F) use the ROM port; WRAM sources (X C0-FD) use the WRAM array.
//   Any other X reads FF.
// - WR: oam_we=1, oam_addr=i, oam_wdata=byte. After i=DMA_LEN-1 the FSM returns to IDLE.
//   dma_active falls in the cycle after the last WR.
// - Total time is 1 + 2*DMA_LEN cycles (321).
// - Write to FF46 during DMA: restarts the DMA at START with the new X and i=0.
// CPU bus while dma_active:
// - Only HRAM, IE and FF46 are accessible.
// - Other reads return FF with cpu_rvalid=1; other writes are dropped.
// - DMA owns rom_* and oam_*; a CPU OAM write never collides with DMA.
// Reset mid-DMA aborts immediately: oam_we=0, FSM=IDLE, no further OAM writes.
// TESTING
// - Write C123<-5A, read C123 -> rvalid=1 next cycle, rdata=5A; read E123 -> 5A (echo).
// - Read 0150 with rom_rdata=C3 in the following cycle -> rom_addr=0150, rom_rd=1;
//   rdata=C3 one cycle later. Write 0150 -> no effect.
// - Write FF46<-C0, with C000+i preloaded with i^A5 -> 160 oam_we pulses at addr i, data i^A5.
//   dma_active is high for exactly 321 cycles.
// - During DMA: HRAM FF90 write 77 then read -> 77; read C000 -> FF; write FE10 -> no CPU oam_we.
// - Assert rst_n low at byte 40 of a DMA -> oam_we=0 at once, dma_active=0, ie=00, FF46 reads 00.
// - cpu_rd and cpu_wr together at FFFF with data 1F -> ie=1F, cpu_rvalid=0.
//   Read A000 -> rdata FF.

Source files
------------

// File: rtl/sm83_mem_responder.sv
// sm83_mem_responder
// Memory-side responder for SM83 bus requests. Decodes the CPU address and
// services ROM (external sync port), internal WRAM (with echo), internal HRAM,
// the OAM write port, the IE register and the OAM DMA register, and runs the
// OAM DMA engine, which takes over the ROM/OAM ports while it runs.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cpu_addr/wdata/rd/wr    one request per cycle; rd+wr together is a write
//   cpu_rdata/cpu_rvalid    read response, one cycle after cpu_rd
//   rom_addr/rom_rd         ROM request (CPU or DMA); rom_rdata returns next cycle
//   rom_rdata               ROM read data
//   oam_addr/wdata/we       OAM write port (CPU or DMA)
//   ie                      interrupt-enable register (FFFF)
//   dma_active              OAM DMA in progress
//
// state   | meaning
// S_IDLE  | no DMA; CPU owns every region
// S_START | one-cycle DMA setup after an FF46 write
// S_RD    | source read for byte idx (ROM port or WRAM array)
// S_WR    | OAM write of byte idx; after the last byte back to S_IDLE

module sm83_mem_responder #(
  parameter int WRAM_AW   = 13,
  parameter int HRAM_SIZE = 127,
  parameter int DMA_LEN   = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic [14:0] rom_addr,
  output logic        rom_rd,
  input  logic [7:0]  rom_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic [7:0]  ie,
  output logic        dma_active
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RD, S_WR} dma_state_e;

  localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

  logic [7:0] wram_mem [0:(2**WRAM_AW)-1];
  logic [7:0] hram_mem [0:HRAM_SIZE-1];

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] ff46_q, ff46_d;
  logic [7:0] ie_q, ie_d;
  logic [7:0] dma_byte_q, dma_byte_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;
  logic       rom_sel_q, rom_sel_d;
  logic       oam_we_q, oam_we_d;
  logic [7:0] oam_addr_q, oam_addr_d;
  logic [7:0] oam_wdata_q, oam_wdata_d;
  logic       wram_we, hram_we;

  logic is_rom, is_wram, is_oam, is_ff46, is_hram, is_ie;
  logic cpu_rd_only, cpu_ok, dma_wr;
  logic dma_src_rom, dma_src_wram;
  logic [WRAM_AW-1:0] dma_wram_idx;

  assign is_rom  = ~cpu_addr[15];
  assign is_wram = (cpu_addr >= 16'hC000) && (cpu_addr <= 16'hFDFF);
  assign is_oam  = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
  assign is_ff46 = (cpu_addr == 16'hFF46);
  assign is_hram = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign is_ie   = (cpu_addr == 16'hFFFF);

  assign dma_active  = (state_q != S_IDLE);
  assign cpu_rd_only = cpu_rd & ~cpu_wr;
  // While DMA runs only HRAM, IE and FF46 stay reachable from the CPU.
  assign cpu_ok      = ~dma_active | is_hram | is_ie | is_ff46;
  assign dma_wr      = (state_q == S_WR);

  assign dma_src_rom  = ~ff46_q[7];
  assign dma_src_wram = (ff46_q >= 8'hC0) && (ff46_q <= 8'hFD);
  assign dma_wram_idx = {ff46_q[WRAM_AW-9:0], idx_q};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ff46_d      = ff46_q;
    ie_d        = ie_q;
    dma_byte_d  = dma_byte_q;
    rdata_d     = 8'hFF;
    rvalid_d    = cpu_rd_only;
    rom_sel_d   = 1'b0;
    oam_we_d    = 1'b0;
    oam_addr_d  = oam_addr_q;
    oam_wdata_d = oam_wdata_q;
    wram_we     = 1'b0;
    hram_we     = 1'b0;

    case (state_q)
      S_START: state_d = S_RD;
      S_RD: begin
        dma_byte_d = dma_src_wram ? wram_mem[dma_wram_idx] : 8'hFF;
        state_d    = S_WR;
      end
      S_WR: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_RD;
        end
      end
      default: ;
    endcase

    if (cpu_rd_only && cpu_ok) begin
      if (is_rom)       rom_sel_d = 1'b1;
      else if (is_wram) rdata_d   = wram_mem[cpu_addr[WRAM_AW-1:0]];
      else if (is_hram) rdata_d   = hram_mem[cpu_addr[6:0]];
      else if (is_ie)   rdata_d   = ie_q;
      else if (is_ff46) rdata_d   = ff46_q;
    end

    // CPU writes come last so an FF46 write overrides the DMA sequencing.
    if (cpu_wr && cpu_ok) begin
      if (is_wram) begin
        wram_we = 1'b1;
      end else if (is_oam) begin
        oam_we_d    = 1'b1;
        oam_addr_d  = cpu_addr[7:0];
        oam_wdata_d = cpu_wdata;
      end else if (is_hram) begin
        hram_we = 1'b1;
      end else if (is_ie) begin
        ie_d = cpu_wdata;
      end else if (is_ff46) begin
        ff46_d  = cpu_wdata;
        idx_d   = 8'd0;
        state_d = S_START;
      end
    end
  end

  always_comb begin
    rom_rd   = 1'b0;
    rom_addr = 15'd0;
    if (state_q == S_RD && dma_src_rom) begin
      rom_rd   = 1'b1;
      rom_addr = {ff46_q[6:0], idx_q};
    end else if (cpu_rd_only && !dma_active && is_rom) begin
      rom_rd   = 1'b1;
      rom_addr = cpu_addr[14:0];
    end
  end

  // ROM data arrives in the response cycle, so it bypasses the read register.
  assign cpu_rdata  = rom_sel_q ? rom_rdata : rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign ie         = ie_q;
  assign oam_we     = oam_we_q | dma_wr;
  assign oam_addr   = dma_wr ? idx_q : oam_addr_q;
  assign oam_wdata  = dma_wr ? (dma_src_rom ? rom_rdata : dma_byte_q) : oam_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 8'd0;
      ff46_q      <= 8'd0;
      ie_q        <= 8'd0;
      dma_byte_q  <= 8'hFF;
      rdata_q     <= 8'hFF;
      rvalid_q    <= 1'b0;
      rom_sel_q   <= 1'b0;
      oam_we_q    <= 1'b0;
      oam_addr_q  <= 8'd0;
      oam_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ff46_q      <= ff46_d;
      ie_q        <= ie_d;
      dma_byte_q  <= dma_byte_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      rom_sel_q   <= rom_sel_d;
      oam_we_q    <= oam_we_d;
      oam_addr_q  <= oam_addr_d;
      oam_wdata_q <= oam_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wram_we) wram_mem[cpu_addr[WRAM_AW-1:0]] <= cpu_wdata;
    if (hram_we) hram_mem[cpu_addr[6:0]] <= cpu_wdata;
  end

endmodule

// File: tb/tb_sm83_mem_responder.sv
module tb_sm83_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = 16'd0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [14:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_rdata = 8'd0;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic [7:0]  ie;
  logic        dma_active;

  sm83_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_rdata(rom_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .ie(ie), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_func(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
  endfunction

  // External synchronous ROM: data for the address strobed in cycle N shows in N+1.
  always @(posedge clk) if (rom_rd) rom_rdata <= rom_func(rom_addr);

  typedef struct {int cyc; logic [7:0] data;} rd_e;
  typedef struct {int cyc; logic [7:0] addr; logic [7:0] data;} oam_e;
  rd_e  rq[$];
  oam_e oq[$];

  logic [7:0] m_wram [0:8191];
  logic [7:0] m_hram [0:126];
  logic [7:0] m_ie = 8'd0;
  logic [7:0] m_ff46 = 8'd0;
  int act_lo = 1, act_hi = 0;
  int n_vec = 0, n_err = 0;
  int dma_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_ln(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    n_err++;
    $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
  endtask

  function automatic bit model_active(input int c);
    return (c >= act_lo) && (c <= act_hi);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dma(input int c, input logic [7:0] x);
    logic [15:0] src;
    logic [7:0]  b;
    m_ff46 = x;
    while (oq.size() > 0 && oq[$].cyc > c) void'(oq.pop_back());
    if (!model_active(c)) act_lo = c + 1;
    act_hi = c + 1 + 2 * 160;
    for (int i = 0; i < 160; i++) begin
      src = {x, 8'(i)};
      if (x < 8'h80)                    b = rom_func(src[14:0]);
      else if (x >= 8'hC0 && x <= 8'hFD) b = m_wram[src[12:0]];
      else                              b = 8'hFF;
      oq.push_back('{c + 3 + 2 * i, 8'(i), b});
    end
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
    int c;
    bit act, open;
    logic [7:0] exp;
    c    = cyc;
    act  = model_active(c);
    open = (a >= 16'hFF80) || (a == 16'hFF46);
    cpu_addr = a; cpu_wdata = d; cpu_rd = rd; cpu_wr = wr;
    if (wr) begin
      if (!act || open) begin
        if (a >= 16'hC000 && a <= 16'hFDFF)      m_wram[a[12:0]] = d;
        else if (a >= 16'hFE00 && a <= 16'hFE9F) oq.push_back('{c + 1, a[7:0], d});
        else if (a >= 16'hFF80 && a <= 16'hFFFE) m_hram[int'(a) - 'hFF80] = d;
        else if (a == 16'hFFFF)                  m_ie = d;
        else if (a == 16'hFF46)                  start_dma(c, d);
      end
    end else if (rd) begin
      exp = 8'hFF;
      if (!act || open) begin
        if (a < 16'h8000)                        exp = rom_func(a[14:0]);
        else if (a >= 16'hC000 && a <= 16'hFDFF) exp = m_wram[a[12:0]];
        else if (a >= 16'hFF80 && a <= 16'hFFFE) exp = m_hram[int'(a) - 'hFF80];
        else if (a == 16'hFFFF)                  exp = m_ie;
        else if (a == 16'hFF46)                  exp = m_ff46;
      end
      rq.push_back('{c + 1, exp});
    end
    tick();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic rand_req();
    int r;
    bit rd, wr;
    logic [15:0] a;
    r  = $urandom_range(0, 7);
    rd = 1'($urandom_range(0, 1));
    wr = 1'($urandom_range(0, 1));
    case (r)
      0: a = 16'($urandom_range(0, 'h7FFF));
      1: a = 16'('hC000 + $urandom_range(0, 'h1FFF));
      2: a = 16'('hE000 + $urandom_range(0, 'h1DFF));
      3: a = 16'('hFE00 + $urandom_range(0, 'h9F));
      4: a = 16'('hFF80 + $urandom_range(0, 'h7E));
      5: a = 16'hFFFF;
      6: a = 16'('hA000 + $urandom_range(0, 'h1FFF));
      default: begin a = 16'hFF46; rd = 1'b1; wr = 1'b0; end
    endcase
    do_req(rd, wr, a, 8'($urandom));
  endtask

  // Scoreboard monitor: read responses, OAM writes and dma_active.
  always @(negedge clk) begin
    rd_e  re;
    oam_e oe;
    if (rst_n) begin
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        fail_ln("rvalid_missing", 0, 1);
        void'(rq.pop_front());
      end
      if (cpu_rvalid) begin
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
          re = rq.pop_front();
          chk("rdata", cpu_rdata, re.data);
        end else begin
          fail_ln("rvalid_unexpected", 1, 0);
        end
      end
      while (oq.size() > 0 && oq[0].cyc < cyc) begin
        fail_ln("oam_we_missing", 0, 1);
        void'(oq.pop_front());
      end
      if (oam_we) begin
        if (oq.size() > 0 && oq[0].cyc == cyc) begin
          oe = oq.pop_front();
          chk("oam_addr", oam_addr, oe.addr);
          chk("oam_wdata", oam_wdata, oe.data);
        end else begin
          fail_ln("oam_we_unexpected", 1, 0);
        end
      end
      chk("dma_active", dma_active, model_active(cyc));
      if (dma_active) dma_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_rom_rd", rom_rd, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_oam_we", oam_we, 0);
    chk("rst_oam_addr", oam_addr, 0);
    chk("rst_oam_wdata", oam_wdata, 0);
    chk("rst_ie", ie, 0);
    chk("rst_dma_active", dma_active, 0);
    rst_n = 1'b1;
    tick();

    // Fill memories so every later read has a defined expectation.
    for (int i = 0; i < 8192; i++) do_req(0, 1, 16'('hC000 + i), 8'($urandom));
    for (int i = 0; i < 127; i++) do_req(0, 1, 16'('hFF80 + i), 8'($urandom));

    do_req(0, 1, 16'hC123, 8'h5A);
    do_req(1, 0, 16'hC123, 8'h00);
    do_req(1, 0, 16'hE123, 8'h00);

    cpu_addr = 16'h0150; cpu_rd = 1'b1;
    rq.push_back('{cyc + 1, rom_func(15'h0150)});
    #1;
    chk("cpu_rom_rd", rom_rd, 1);
    chk("cpu_rom_addr", rom_addr, 15'h0150);
    tick();
    cpu_rd = 1'b0;
    do_req(0, 1, 16'h0150, 8'hAA);
    do_req(1, 0, 16'h0150, 8'h00);

    do_req(1, 1, 16'hFFFF, 8'h1F);
    chk("ie_rdwr", ie, 8'h1F);
    do_req(1, 0, 16'hA000, 8'h00);
    do_req(1, 0, 16'hFFFF, 8'h00);

    repeat (400) rand_req();

    for (int i = 0; i < 160; i++) do_req(0, 1, 16'('hC000 + i), 8'(i) ^ 8'hA5);
    dma_cnt = 0;
    do_req(0, 1, 16'hFF46, 8'hC0);
    repeat (20) tick();
    do_req(0, 1, 16'hFF90, 8'h77);
    do_req(1, 0, 16'hFF90, 8'h00);
    do_req(1, 0, 16'hC000, 8'h00);
    do_req(0, 1, 16'hFE10, 8'h33);
    repeat (150) rand_req();
    repeat (200) tick();
    chk("dma_cycles", dma_cnt, 321);

    do_req(0, 1, 16'hFF46, 8'h12);
    repeat (60) rand_req();
    do_req(0, 1, 16'hFF46, 8'h20);
    repeat (61) rand_req();
    do_req(0, 1, 16'hFF46, 8'hA0);
    repeat (100) rand_req();
    repeat (250) tick();
    do_req(0, 1, 16'hFF46, 8'hD5);
    repeat (330) rand_req();

    do_req(0, 1, 16'hFFFF, 8'h5C);
    do_req(0, 1, 16'hFF46, 8'hC0);
    k = cyc - 1;
    while (cyc < k + 83) tick();
    chk("pre_rst_oam_we", oam_we, 1);
    rst_n = 1'b0;
    oq.delete();
    rq.delete();
    act_lo = 1; act_hi = 0;
    m_ie = 8'd0; m_ff46 = 8'd0;
    #1;
    chk("midrst_oam_we", oam_we, 0);
    chk("midrst_dma_active", dma_active, 0);
    chk("midrst_ie", ie, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_req(1, 0, 16'hFF46, 8'h00);
    do_req(1, 0, 16'hFFFF, 8'h00);
    repeat (200) rand_req();
    repeat (5) tick();
    chk("rdq_drained", rq.size(), 0);
    chk("oamq_drained", oq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
